// File: rtl/or1200_checker_pkg.sv
// Shared definitions for the OR1200 privilege-checker alarm block:
// FSM encoding, cause-vector bit positions and parameter defaults.
package or1200_checker_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StPend  = 2'd1,
        StAlarm = 2'd2
    } state_e;

    localparam int unsigned CauseImmu = 0;
    localparam int unsigned CauseDmmu = 1;
    localparam int unsigned CauseSupv = 2;
    localparam int unsigned CauseW    = 3;

    localparam int unsigned DefThresh = 2;
    localparam int unsigned DefWindow = 16;
    localparam int unsigned EpCntW    = 8;
    localparam int unsigned TotalW    = 16;

endpackage

// File: rtl/or1200_checker_satcnt.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module or1200_checker_satcnt #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [Width-1:0] cnt_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != {Width{1'b1}})) begin
            cnt_d = cnt_q + Width'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/or1200_checker_alarm.sv
// Windowed violation counter for MMU privilege checks: raises a sticky alarm
// once THRESH violating cycles land within WINDOW cycles of the first one.
module or1200_checker_alarm
    import or1200_checker_pkg::*;
#(
    parameter int unsigned THRESH = DefThresh,
    parameter int unsigned WINDOW = DefWindow
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              chk_en_i,
    input  logic              immu_fault_ok_i,
    input  logic              dmmu_fault_ok_i,
    input  logic              supv_consistent_i,
    input  logic [3:0]        icpu_tag_i,
    input  logic [3:0]        dcpu_tag_i,
    input  logic              clr_req_i,
    output logic              alarm_o,
    output logic              alarm_irq_o,
    output logic              clr_ack_o,
    output logic [CauseW-1:0] first_cause_o,
    output logic [CauseW-1:0] sticky_cause_o,
    output logic [3:0]        first_itag_o,
    output logic [3:0]        first_dtag_o,
    output logic [TotalW-1:0] viol_total_o
);

    localparam logic [EpCntW-1:0] WinInit = EpCntW'(WINDOW - 1);
    localparam logic [EpCntW-1:0] HitLast = EpCntW'(THRESH - 1);

    state_e              state_q;
    logic [EpCntW-1:0]   win_cnt_q;
    logic [EpCntW-1:0]   hit_cnt;
    logic [CauseW-1:0]   first_cause_q, sticky_cause_q, v;
    logic [3:0]          first_itag_q, first_dtag_q;
    logic                alarm_q, alarm_irq_q, clr_ack_q;
    logic                viol, thresh_hit, win_expire, clr_accept, hit_clr, hit_inc;

    always_comb begin
        v            = '0;
        v[CauseImmu] = chk_en_i & ~immu_fault_ok_i;
        v[CauseDmmu] = chk_en_i & ~dmmu_fault_ok_i;
        v[CauseSupv] = chk_en_i & ~supv_consistent_i;
    end

    assign viol       = |v;
    assign thresh_hit = (state_q == StPend) && viol && (hit_cnt == HitLast);
    assign win_expire = (state_q == StPend) && (win_cnt_q == '0) && !thresh_hit;
    assign clr_accept = (state_q == StAlarm) && clr_req_i && !viol;
    assign hit_clr    = win_expire || clr_accept;
    // hit_cnt is always zero in IDLE, so an increment there loads the first hit.
    assign hit_inc    = viol && ((state_q == StIdle) || (state_q == StPend));

    or1200_checker_satcnt #(
        .Width (EpCntW)
    ) u_hit_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (hit_clr),
        .inc_i  (hit_inc),
        .cnt_o  (hit_cnt)
    );

    or1200_checker_satcnt #(
        .Width (TotalW)
    ) u_viol_total (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (1'b0),
        .inc_i  (viol),
        .cnt_o  (viol_total_o)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= StIdle;
            win_cnt_q      <= '0;
            first_cause_q  <= '0;
            sticky_cause_q <= '0;
            first_itag_q   <= '0;
            first_dtag_q   <= '0;
            alarm_q        <= 1'b0;
            alarm_irq_q    <= 1'b0;
            clr_ack_q      <= 1'b0;
        end else begin
            alarm_irq_q <= 1'b0;
            clr_ack_q   <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (viol) begin
                        win_cnt_q      <= WinInit;
                        first_cause_q  <= v;
                        sticky_cause_q <= v;
                        first_itag_q   <= icpu_tag_i;
                        first_dtag_q   <= dcpu_tag_i;
                        if (THRESH == 1) begin
                            state_q     <= StAlarm;
                            alarm_q     <= 1'b1;
                            alarm_irq_q <= 1'b1;
                        end else begin
                            state_q <= StPend;
                        end
                    end
                end
                StPend: begin
                    if (thresh_hit) begin
                        state_q        <= StAlarm;
                        alarm_q        <= 1'b1;
                        alarm_irq_q    <= 1'b1;
                        sticky_cause_q <= sticky_cause_q | v;
                    end else if (win_expire) begin
                        state_q        <= StIdle;
                        first_cause_q  <= '0;
                        sticky_cause_q <= '0;
                        first_itag_q   <= '0;
                        first_dtag_q   <= '0;
                    end else begin
                        win_cnt_q      <= win_cnt_q - EpCntW'(1);
                        sticky_cause_q <= sticky_cause_q | v;
                    end
                end
                StAlarm: begin
                    if (clr_accept) begin
                        state_q        <= StIdle;
                        alarm_q        <= 1'b0;
                        clr_ack_q      <= 1'b1;
                        win_cnt_q      <= '0;
                        first_cause_q  <= '0;
                        sticky_cause_q <= '0;
                        first_itag_q   <= '0;
                        first_dtag_q   <= '0;
                    end else begin
                        sticky_cause_q <= sticky_cause_q | v;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign alarm_o        = alarm_q;
    assign alarm_irq_o    = alarm_irq_q;
    assign clr_ack_o      = clr_ack_q;
    assign first_cause_o  = first_cause_q;
    assign sticky_cause_o = sticky_cause_q;
    assign first_itag_o   = first_itag_q;
    assign first_dtag_o   = first_dtag_q;

endmodule
